// File: rtl/line_fill_ctrl.sv
// Line fill controller: optionally writes a dirty victim line back to the system bus,
// then burst-reads the requested line into the cache data memory.
module line_fill_ctrl #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               fetch_req,
  output logic                                               fetch_gnt,
  input  logic [1:0]                                         fetch_cmd,
  input  logic [$clog2(list_depth)-1:0]                      fetch_tag,
  input  logic [addr_width-1:0]                              fetch_addr,
  input  logic [addr_width-1:0]                              fetch_addr_pre,
  output logic                                               fetch_done,
  output logic                                               mem_ren,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0]   mem_raddr,
  input  logic                                               mem_rready,
  input  logic [data_width-1:0]                              mem_rdata,
  input  logic                                               mem_rdata_valid,
  output logic                                               mem_wen,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0]   mem_waddr,
  output logic [data_width-1:0]                              mem_wdata,
  input  logic                                               mem_wready,
  output logic                                               bus_wr_valid,
  output logic [addr_width-1:0]                              bus_wr_addr,
  output logic [data_width-1:0]                              bus_wr_data,
  input  logic                                               bus_wr_ready,
  output logic                                               bus_rd_req,
  output logic [addr_width-1:0]                              bus_rd_addr,
  input  logic                                               bus_rd_gnt,
  input  logic [data_width-1:0]                              bus_rd_data,
  input  logic                                               bus_rd_valid,
  output logic                                               bus_rd_ready
);

  localparam int tag_w = $clog2(list_depth);
  localparam int cnt_w = $clog2(list_width);
  localparam logic [cnt_w-1:0] last_word = cnt_w'(list_width - 1);
  localparam logic [addr_width-1:0] word_bytes = addr_width'(data_width / 8);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WB_RD     = 3'd1;
  localparam logic [2:0] WB_WAIT   = 3'd2;
  localparam logic [2:0] WB_BUS    = 3'd3;
  localparam logic [2:0] FILL_REQ  = 3'd4;
  localparam logic [2:0] FILL_DATA = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  logic [2:0]            state;
  logic [cnt_w-1:0]      cnt;
  logic [1:0]            cmd_q;
  logic [tag_w-1:0]      tag_q;
  logic [addr_width-1:0] addr_q;
  logic [addr_width-1:0] addr_pre_q;
  logic [data_width-1:0] word_q;
  logic                  fill_active;
  logic                  beat_taken;

  assign fill_active = (state == FILL_DATA);
  assign beat_taken  = fill_active && bus_rd_valid && mem_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      addr_pre_q <= '0;
      word_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req) begin
            cmd_q      <= fetch_cmd;
            tag_q      <= fetch_tag;
            addr_q     <= fetch_addr;
            addr_pre_q <= fetch_addr_pre;
            cnt        <= '0;
            state      <= (fetch_cmd == 2'b10) ? WB_RD : FILL_REQ;
          end
        end
        WB_RD: begin
          if (mem_rready) state <= WB_WAIT;
        end
        WB_WAIT: begin
          if (mem_rdata_valid) begin
            word_q <= mem_rdata;
            state  <= WB_BUS;
          end
        end
        WB_BUS: begin
          if (bus_wr_ready) begin
            if (cnt == last_word) begin
              cnt   <= '0;
              state <= FILL_REQ;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= WB_RD;
            end
          end
        end
        FILL_REQ: begin
          if (bus_rd_gnt) begin
            cnt   <= '0;
            state <= FILL_DATA;
          end
        end
        FILL_DATA: begin
          if (beat_taken) begin
            cnt <= cnt + 1'b1;
            if (cnt == last_word) state <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every address/data output is forced to zero outside the state that owns it.
  assign fetch_gnt  = (state == IDLE);
  assign fetch_done = (state == DONE);

  assign mem_ren   = (state == WB_RD);
  assign mem_raddr = mem_ren ? {tag_q, cnt} : '0;

  // The command check keeps fill-only requests off the write bus even if the FSM misbehaves.
  assign bus_wr_valid = (state == WB_BUS) && (cmd_q == 2'b10);
  assign bus_wr_addr  = bus_wr_valid ? (addr_pre_q + addr_width'(cnt) * word_bytes) : '0;
  assign bus_wr_data  = bus_wr_valid ? word_q : '0;

  assign bus_rd_req  = (state == FILL_REQ);
  assign bus_rd_addr = bus_rd_req ? addr_q : '0;

  assign bus_rd_ready = fill_active && mem_wready;
  assign mem_wen      = fill_active && bus_rd_valid;
  assign mem_waddr    = fill_active ? {tag_q, cnt} : '0;
  assign mem_wdata    = fill_active ? bus_rd_data : '0;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Randomized bench for line_fill_ctrl: plays cache memory and system bus, and compares
// the observed transactions against a line-level model of victim contents and fill data.
module tb_line_fill_ctrl;

  localparam int AW  = 32;
  localparam int LD  = 4;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int TW  = 2;
  localparam int MAW = 4;
  localparam logic [142:0] RST_OUTS = {1'b1, 142'd0};

  logic           clk;
  logic           rst_n;
  logic           fetch_req;
  logic           fetch_gnt;
  logic [1:0]     fetch_cmd;
  logic [TW-1:0]  fetch_tag;
  logic [AW-1:0]  fetch_addr;
  logic [AW-1:0]  fetch_addr_pre;
  logic           fetch_done;
  logic           mem_ren;
  logic [MAW-1:0] mem_raddr;
  logic           mem_rready;
  logic [DW-1:0]  mem_rdata;
  logic           mem_rdata_valid;
  logic           mem_wen;
  logic [MAW-1:0] mem_waddr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_wready;
  logic           bus_wr_valid;
  logic [AW-1:0]  bus_wr_addr;
  logic [DW-1:0]  bus_wr_data;
  logic           bus_wr_ready;
  logic           bus_rd_req;
  logic [AW-1:0]  bus_rd_addr;
  logic           bus_rd_gnt;
  logic [DW-1:0]  bus_rd_data;
  logic           bus_rd_valid;
  logic           bus_rd_ready;

  int total;
  int passed;

  // model_cache is what each line should hold; tb_mem is what the DUT actually wrote.
  logic [DW-1:0] model_cache [LD*LW];
  logic [DW-1:0] tb_mem      [LD*LW];

  line_fill_ctrl #(.addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag),
    .fetch_addr(fetch_addr), .fetch_addr_pre(fetch_addr_pre), .fetch_done(fetch_done),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .bus_wr_valid(bus_wr_valid), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
    .bus_wr_ready(bus_wr_ready), .bus_rd_req(bus_rd_req), .bus_rd_addr(bus_rd_addr),
    .bus_rd_gnt(bus_rd_gnt), .bus_rd_data(bus_rd_data), .bus_rd_valid(bus_rd_valid),
    .bus_rd_ready(bus_rd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [142:0] outs();
    return {fetch_gnt, fetch_done, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
            bus_wr_valid, bus_wr_addr, bus_wr_data, bus_rd_req, bus_rd_addr, bus_rd_ready};
  endfunction

  task automatic set_idle();
    fetch_req       = 1'b0;
    fetch_cmd       = 2'b00;
    fetch_tag       = '0;
    fetch_addr      = '0;
    fetch_addr_pre  = '0;
    mem_rready      = 1'b0;
    mem_rdata       = '0;
    mem_rdata_valid = 1'b0;
    mem_wready      = 1'b0;
    bus_wr_ready    = 1'b0;
    bus_rd_gnt      = 1'b0;
    bus_rd_data     = '0;
    bus_rd_valid    = 1'b0;
  endtask

  // Drives one command to completion with bus/memory responders, then checks the transaction log.
  task automatic run_cmd(input logic [1:0] cmd, input int tag, input logic [AW-1:0] addr,
                         input logic [AW-1:0] addr_pre, input bit rnd, input int wr_stall_word,
                         input int wready_stall_beat, input int abort_beat, input bit keep_req,
                         input int exp_done_cyc, input string name);
    logic [DW-1:0]  beats [LW];
    logic [AW-1:0]  exp_wa [$];
    logic [DW-1:0]  exp_wd [$];
    logic [AW-1:0]  got_wa [$];
    logic [DW-1:0]  got_wd [$];
    logic [MAW-1:0] got_ma [$];
    logic [DW-1:0]  got_md [$];
    logic [MAW-1:0] pend_raddr;
    logic [AW-1:0]  held_a;
    logic [DW-1:0]  held_d;
    logic [AW-1:0]  got_rd_addr;
    bit pending, granted, held, done;
    int reads, rd_reqs, beat_idx, wait_cyc, done_cyc, wb_before;
    int gnt_err, hold_err, beat_err, wr_stall, wready_stall;

    pending = 0; granted = 0; held = 0; done = 0;
    reads = 0; rd_reqs = 0; beat_idx = 0; wait_cyc = 0; done_cyc = -1; wb_before = -1;
    gnt_err = 0; hold_err = 0; beat_err = 0; wr_stall = 0; wready_stall = 0;
    pend_raddr = '0; held_a = '0; held_d = '0; got_rd_addr = '0;

    for (int i = 0; i < LW; i++) begin
      beats[i] = $urandom;
      if (cmd == 2'b10) begin
        exp_wa.push_back(addr_pre + AW'(i * (DW / 8)));
        exp_wd.push_back(model_cache[tag*LW + i]);
      end
    end

    do begin
      @(negedge clk);
      set_idle();
      fetch_req      = 1'b1;
      fetch_cmd      = cmd;
      fetch_tag      = TW'(tag);
      fetch_addr     = addr;
      fetch_addr_pre = addr_pre;
      #1;
      if (!fetch_gnt) wait_cyc++;
    end while (!fetch_gnt && wait_cyc < 50);
    total++;
    if (wait_cyc !== 0) $display("[TB] FAIL %s handshake_wait: got %0d cycles expected 0", name, wait_cyc);
    else passed++;
    if (!fetch_gnt) begin
      fetch_req = 1'b0;
      return;
    end

    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      fetch_req       = keep_req;
      fetch_cmd       = 2'($urandom);
      fetch_tag       = TW'($urandom);
      fetch_addr      = $urandom;
      fetch_addr_pre  = $urandom;
      mem_rready      = rnd ? 1'($urandom) : 1'b1;
      mem_rdata_valid = pending && (rnd ? 1'($urandom) : 1'b1);
      mem_rdata       = mem_rdata_valid ? tb_mem[pend_raddr] : $urandom;
      bus_wr_ready    = rnd ? 1'($urandom) : 1'b1;
      if (bus_wr_valid && got_wa.size() == wr_stall_word && wr_stall < 3) begin
        bus_wr_ready = 1'b0;
        wr_stall++;
      end
      bus_rd_gnt   = rnd ? 1'($urandom) : 1'b1;
      bus_rd_valid = granted && beat_idx < LW && (rnd ? 1'($urandom) : 1'b1);
      bus_rd_data  = (beat_idx < LW) ? beats[beat_idx % LW] : $urandom;
      mem_wready   = rnd ? 1'($urandom) : 1'b1;
      if (granted && beat_idx == wready_stall_beat && wready_stall < 2) begin
        mem_wready   = 1'b0;
        bus_rd_valid = 1'b1;
        wready_stall++;
      end
      if (granted && beat_idx == abort_beat) begin
        rst_n = 1'b0;
        set_idle();
        #1;
        total++;
        if (outs() !== RST_OUTS) $display("[TB] FAIL %s abort_outputs: got %h expected %h", name, outs(), RST_OUTS);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (outs() !== RST_OUTS) $display("[TB] FAIL %s abort_outputs_edge: got %h expected %h", name, outs(), RST_OUTS);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < beat_idx; i++) model_cache[tag*LW + i] = beats[i];
        return;
      end
      #1;
      if (fetch_gnt) gnt_err++;
      if (mem_rdata_valid) pending = 0;
      if (mem_ren && mem_rready) begin
        reads++;
        pending    = 1;
        pend_raddr = mem_raddr;
      end
      if (held && (!bus_wr_valid || bus_wr_addr !== held_a || bus_wr_data !== held_d)) hold_err++;
      if (bus_wr_valid && bus_wr_ready) begin
        got_wa.push_back(bus_wr_addr);
        got_wd.push_back(bus_wr_data);
        held = 0;
      end else if (bus_wr_valid) begin
        held   = 1;
        held_a = bus_wr_addr;
        held_d = bus_wr_data;
      end else begin
        held = 0;
      end
      if (bus_rd_req && bus_rd_gnt) begin
        rd_reqs++;
        got_rd_addr = bus_rd_addr;
        granted     = 1;
        wb_before   = got_wa.size();
      end
      if ((mem_wen && mem_wready) !== (bus_rd_valid && bus_rd_ready)) beat_err++;
      if (mem_wen && mem_wready) begin
        got_ma.push_back(mem_waddr);
        got_md.push_back(mem_wdata);
        tb_mem[mem_waddr] = mem_wdata;
      end
      if (bus_rd_valid && bus_rd_ready) beat_idx++;
      if (fetch_done) begin
        done     = 1;
        done_cyc = cyc;
      end
    end

    total++;
    if (!done) $display("[TB] FAIL %s done_timeout: got no fetch_done expected one within 400 cycles", name);
    else passed++;
    if (exp_done_cyc > 0) begin
      total++;
      if (done_cyc !== exp_done_cyc) $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done_cyc);
      else passed++;
    end
    total++;
    if (got_wa.size() !== exp_wa.size()) $display("[TB] FAIL %s wb_count: got %0d expected %0d", name, got_wa.size(), exp_wa.size());
    else passed++;
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      total++;
      if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i])
        $display("[TB] FAIL %s wb_word%0d: got %h/%h expected %h/%h", name, i, got_wa[i], got_wd[i], exp_wa[i], exp_wd[i]);
      else passed++;
    end
    total++;
    if (reads !== ((cmd == 2'b10) ? LW : 0)) $display("[TB] FAIL %s victim_reads: got %0d expected %0d", name, reads, (cmd == 2'b10) ? LW : 0);
    else passed++;
    total++;
    if (rd_reqs !== 1 || got_rd_addr !== addr) $display("[TB] FAIL %s fill_request: got %0d reqs addr %h expected 1 req addr %h", name, rd_reqs, got_rd_addr, addr);
    else passed++;
    total++;
    if (wb_before !== exp_wa.size()) $display("[TB] FAIL %s wb_before_fill: got %0d expected %0d", name, wb_before, exp_wa.size());
    else passed++;
    total++;
    if (got_ma.size() !== LW) $display("[TB] FAIL %s fill_count: got %0d expected %0d", name, got_ma.size(), LW);
    else passed++;
    for (int i = 0; i < LW && i < got_ma.size(); i++) begin
      total++;
      if (got_ma[i] !== MAW'(tag*LW + i) || got_md[i] !== beats[i])
        $display("[TB] FAIL %s fill_word%0d: got %h/%h expected %h/%h", name, i, got_ma[i], got_md[i], MAW'(tag*LW + i), beats[i]);
      else passed++;
    end
    total++;
    if (gnt_err !== 0) $display("[TB] FAIL %s gnt_while_busy: got %0d cycles expected 0", name, gnt_err);
    else passed++;
    total++;
    if (hold_err !== 0) $display("[TB] FAIL %s wb_hold: got %0d unstable cycles expected 0", name, hold_err);
    else passed++;
    total++;
    if (beat_err !== 0) $display("[TB] FAIL %s beat_vs_write: got %0d mismatched cycles expected 0", name, beat_err);
    else passed++;
    for (int i = 0; i < LW; i++) model_cache[tag*LW + i] = beats[i];

    if (!keep_req) begin
      @(negedge clk);
      set_idle();
      #1;
      total++;
      if ({fetch_gnt, fetch_done} !== 2'b10) $display("[TB] FAIL %s after_done gnt/done: got %b expected 10", name, {fetch_gnt, fetch_done});
      else passed++;
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== RST_OUTS) $display("[TB] FAIL reset_async: got %h expected %h", outs(), RST_OUTS);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (outs() !== RST_OUTS) $display("[TB] FAIL reset_held: got %h expected %h", outs(), RST_OUTS);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_only();
    run_cmd(2'b01, 2, 32'h100, 32'h0, 0, -1, -1, -1, 0, 2 + LW, "fill_only");
  endtask

  task automatic test_writeback();
    run_cmd(2'b10, 1, 32'h340, 32'h200, 0, -1, -1, -1, 0, 3*LW + 2 + LW, "writeback");
  endtask

  task automatic test_wb_stall();
    run_cmd(2'b10, 3, 32'h880, 32'h4C0, 0, 2, -1, -1, 0, 3*LW + 2 + LW + 3, "wb_stall");
  endtask

  task automatic test_wready_stall();
    run_cmd(2'b00, 0, 32'h7F0, 32'h0, 0, -1, 1, -1, 0, 2 + LW + 2, "wready_stall");
  endtask

  task automatic test_back_to_back();
    run_cmd(2'b01, 2, 32'h100, 32'h0, 0, -1, -1, -1, 1, 2 + LW, "b2b_first");
    run_cmd(2'b10, 2, 32'h9A0, 32'h100, 0, -1, -1, -1, 1, 3*LW + 2 + LW, "b2b_second");
    run_cmd(2'b11, 1, 32'h440, 32'h0, 0, -1, -1, -1, 0, 2 + LW, "b2b_third");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [1:0] cmd;
      cmd = $urandom_range(0, 1) ? 2'b10 : 2'($urandom_range(0, 3));
      run_cmd(cmd, $urandom_range(0, LD - 1), $urandom & ~32'hF, $urandom & ~32'hF,
              1, -1, -1, -1, 0, 0, "random");
    end
  endtask

  task automatic test_reset_mid_fill();
    run_cmd(2'b01, 3, 32'h600, 32'h0, 0, -1, -1, 2, 0, 0, "abort");
    run_cmd(2'b01, 3, 32'hA00, 32'h0, 0, -1, -1, -1, 0, 2 + LW, "after_abort");
    run_cmd(2'b10, 3, 32'hB00, 32'hA00, 0, -1, -1, -1, 0, 3*LW + 2 + LW, "wb_after_abort");
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int i = 0; i < LD*LW; i++) begin
      model_cache[i] = $urandom;
      tb_mem[i]      = model_cache[i];
    end
    test_reset();
    test_fill_only();
    test_writeback();
    test_wb_stall();
    test_wready_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/line_fill_ctrl.md
Name: line_fill_ctrl

Overview:
Downstream stage of the read controller. It accepts a line-fetch command (fetch_req/fetch_gnt) carrying cache tag, line address, victim address and command. For a dirty victim it first writes the victim line back to the system bus, then burst-reads the requested line into the cache data memory. It pulses fetch_done when the line is resident.

Parameters:
addr_width, 32, byte address width
list_depth, 4, number of cache lines (tag range)
data_width, 32, bits per word
list_width, 32, words per line

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch command valid
fetch_gnt  out  1  command accepted
fetch_cmd  in  2  2'b10 = writeback then fill; any other value = fill only
fetch_tag  in  $clog2(list_depth)  destination line (tag)
fetch_addr  in  addr_width  line-aligned byte address to fill
fetch_addr_pre  in  addr_width  line-aligned byte address of the victim (writeback target)
fetch_done  out  1  one-cycle pulse: line filled
mem_ren  out  1  cache mem read request (victim)
mem_raddr  out  $clog2(list_depth)+$clog2(list_width)  {tag, word}
mem_rready  in  1  read accepted
mem_rdata  in  data_width  read data
mem_rdata_valid  in  1  read data valid, any cycle after accept
mem_wen  out  1  cache mem write
mem_waddr  out  $clog2(list_depth)+$clog2(list_width)  {tag, word}
mem_wdata  out  data_width  write data
mem_wready  in  1  write accepted
bus_wr_valid  out  1  writeback word valid
bus_wr_addr  out  addr_width  writeback byte address
bus_wr_data  out  data_width  writeback data
bus_wr_ready  in  1  writeback word accepted
bus_rd_req  out  1  burst read request
bus_rd_addr  out  addr_width  burst start address (= latched fetch_addr)
bus_rd_gnt  in  1  burst request accepted
bus_rd_data  in  data_width  burst beat data
bus_rd_valid  in  1  beat valid
bus_rd_ready  out  1  beat accepted; equals mem_wready while in FILL_DATA, else 0

Behaviour:
- Reset (asynchronous, active-low, clock clk): state = IDLE, word counter = 0, all latched fields = 0, every output = 0. Exception: fetch_gnt is 1 out of reset (IDLE).
- Reset mid-operation aborts immediately. A partially written line is left as is; upstream is reset together with this block.
- fetch_gnt = (state == IDLE). A handshake (fetch_req && fetch_gnt) latches cmd, tag, fetch_addr and fetch_addr_pre.
- States and transitions:
  - IDLE: on handshake, go to WB_RD if cmd == 2'b10, else FILL_REQ.
  - WB_RD: mem_ren = 1, mem_raddr = {tag, cnt}. Go to WB_WAIT on mem_rready.
  - WB_WAIT: capture mem_rdata into a word register on mem_rdata_valid (which may arrive in the same cycle as accept+1 or later), then go to WB_BUS.
  - WB_BUS: bus_wr_valid = 1, bus_wr_addr = addr_pre + cnt*(data_width/8), bus_wr_data = captured word. Valid, address and data hold stable until bus_wr_ready. On ready: if cnt == list_width-1, set cnt = 0 and go to FILL_REQ; else cnt++ and go to WB_RD.
  - FILL_REQ: bus_rd_req = 1, bus_rd_addr = latched fetch_addr, held until bus_rd_gnt. Then go to FILL_DATA with cnt = 0.
  - FILL_DATA: bus_rd_ready = mem_wready; mem_wen = bus_rd_valid; mem_waddr = {tag, cnt}; mem_wdata = bus_rd_data. A beat is taken when bus_rd_valid && mem_wready; cnt++ per beat. The last beat (cnt == list_width-1) goes to DONE.
  - DONE: fetch_done = 1 for exactly one cycle, cnt = 0, then IDLE.
- Latency, fill only, zero wait states: handshake at cycle 0; bus_rd_req at cycle 1; with beats every cycle from cycle 2, fetch_done at cycle 2+list_width.
- Widths: cnt is $clog2(list_width) bits. Address adds are addr_width-bit unsigned, with no carry into other state; addresses are assumed line-aligned.
- Only one command is outstanding at a time; fetch_req while busy is ignored (gnt = 0).
- No bus write traffic ever appears for cmd != 2'b10. Writeback always completes before the fill request.

Test Plan:
1. list_width=4: cmd=01, tag=2, addr=0x100. Bus returns beats A,B,C,D back-to-back -> mem writes at {2,0..3} with A..D; bus_rd_addr=0x100; fetch_done one pulse at cycle 6; no bus_wr_valid.
2. cmd=10, tag=1, addr_pre=0x200, victim words W0..W3 -> bus writes 0x200/W0, 0x204/W1, 0x208/W2, 0x20C/W3 in order, then bus_rd_req for fetch_addr; fetch_done after 4 fill beats.
3. bus_wr_ready low 3 cycles on word 2 -> bus_wr_addr/bus_wr_data held stable; no extra mem_ren; all words delivered once.
4. mem_wready low during beat 1 with bus_rd_valid high -> bus_rd_ready=0, cnt unchanged; beat written once when ready rises.
5. fetch_req held high throughout test 1 -> fetch_gnt=0 until after DONE; second command accepted in the cycle IDLE resumes.
6. rst_n low during FILL_DATA beat 2 -> next edge all outputs 0, fetch_gnt=1; new cmd=01 after release completes normally.
